tail_light_decoder: RTL and testbench
=====================================

Name: tail_light_decoder

Overview:
- Receive-side monitor for the turn-signal lamp interface: samples the 3-bit left/right lamp outputs produced by the tail-light FSM.
- Reconstructs the commanded mode (idle/left/right/hazard) and checks every lamp step against the legal sequences.
- Counts completed flash cycles and reports sequence violations.
- Sits beside the lamp FSM in the same clock domain; used in self-checking benches and as an on-chip lamp-fault detector.

Parameters:
- STEP_CYCLES, 1: exact number of consecutive samples each non-zero lamp step must be held.
- IDLE_TIMEOUT, 8: consecutive all-off samples in IDLE after which the reported mode returns to idle.
- CNT_W, 8: width of cycle_count and err_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- l  input  3  left lamp pattern, bit0 = innermost lamp.
- r  input  3  right lamp pattern, bit0 = innermost lamp.
- mode  output  2  last completed mode: 00 idle, 01 left, 10 right, 11 hazard.
- mode_valid  output  1  high once a legal cycle has completed with no error since.
- cycle_done  output  1  one-cycle pulse when a legal flash cycle completes.
- seq_error  output  1  one-cycle pulse on the first illegal sample.
- cycle_count  output  CNT_W  completed legal cycles; wraps to 0.
- err_count  output  CNT_W  detected errors; saturates at all-ones.

Behaviour:
- Clock and reset: inputs sampled on each rising clk edge. All outputs are registered and reflect the sample taken at that edge. Total latency is 1 clock.
- Reset values: asynchronous reset forces state IDLE, hold and idle counters 0, mode=00, mode_valid=0, cycle_done=0, seq_error=0, cycle_count=0, err_count=0.
- Reset mid-cycle: reset asserted mid-cycle discards any partial sequence. No pulse is generated.
- Legal sequences (l/r):
  - Left: 001/000 -> 011/000 -> 111/000 -> 000/000.
  - Right: 000/001 -> 000/011 -> 000/111 -> 000/000.
  - Hazard: 111/111 -> 000/000.
- States: IDLE, L1, L2, L3, R1, R2, R3, HZ, RESYNC.
- IDLE:
  - 000/000: stay, idle counter +1.
  - 001/000 -> L1; 000/001 -> R1; 111/111 -> HZ.
  - Any other sample -> error.
  - Entering L1, R1 or HZ clears the idle counter.
- Step states (L1..L3, R1..R3, HZ):
  - Hold counter counts samples of the current pattern.
  - Same pattern with hold < STEP_CYCLES: stay.
  - Same pattern with hold = STEP_CYCLES: error (held too long).
  - Next legal pattern with hold = STEP_CYCLES: advance and reset hold.
  - Next legal pattern early: error.
  - Any other pattern: error.
- Cycle completion: L3/R3/HZ followed by legal 000/000 at the correct hold returns to IDLE.
  - Same edge: cycle_done=1, mode updated (01/10/11), mode_valid=1, cycle_count+1.
- Error handling:
  - seq_error=1 for one cycle, err_count+1 (saturating), mode_valid=0, mode unchanged, next state RESYNC.
  - RESYNC: waits for 000/000, then goes to IDLE. No further errors are flagged while in RESYNC.
  - A start pattern seen in RESYNC is ignored. A full 000/000 sample is needed first.
- Idle timeout: in IDLE, when the idle counter reaches IDLE_TIMEOUT, mode -> 00 and mode_valid stays at its current value. The counter saturates there.
- Boundary rules:
  - A start pattern on the same edge as the timeout: the start wins and mode is not cleared.
  - Timeout and completion cannot coincide, because completion clears the idle counter.
  - cycle_count wraps from all-ones to 0.
  - err_count holds at all-ones.
- STEP_CYCLES must be >= 1 and IDLE_TIMEOUT >= 1. Other values are unsupported.

Test Plan:
All scenarios use STEP_CYCLES=1, IDLE_TIMEOUT=4, CNT_W=8.
1. Reset, then l/r = 001/000, 011/000, 111/000, 000/000 on consecutive edges -> cycle_done pulses on the 4th edge; mode=01, mode_valid=1, cycle_count=1, seq_error never high.
2. Three back-to-back right cycles (000/001, 000/011, 000/111, 000/000 repeated) -> three cycle_done pulses, 4 clocks apart; mode=10, cycle_count=3.
3. Hazard 111/111, 000/000 alternating 5 times -> cycle_done every 2nd edge, mode=11, cycle_count=5; then 4 further 000/000 samples -> mode=00 on the 4th, mode_valid=1.
4. Left start 001/000, then 111/000 (step skipped) -> seq_error pulses on that edge, err_count=1, mode_valid=0; a following 011/000 raises no error; 000/000 then a legal left cycle -> mode_valid=1, cycle_count+1.
5. 001/000 held for 2 samples -> seq_error on the 2nd sample. Separately, 011/000 applied from IDLE -> immediate seq_error.
6. Assert reset asynchronously mid-way through a left cycle (between clock edges) -> all outputs 0 immediately; after release, the lamp FSM's sequence resumes mid-cycle (011/000) -> seq_error, err_count=1.

Source files
------------

// File: rtl/tail_light_decoder.sv
// Turn-signal lamp monitor: rebuilds idle/left/right/hazard mode from l/r lamp steps and flags illegal sequences.
// One clock of latency; pure observer, so inputs are never stalled and every sample is judged.
module tail_light_decoder #(
  parameter int STEP_CYCLES  = 1,
  parameter int IDLE_TIMEOUT = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       l,
  input  logic [2:0]       r,
  output logic [1:0]       mode,
  output logic             mode_valid,
  output logic             cycle_done,
  output logic             seq_error,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_L1     = 4'd1;
  localparam logic [3:0] S_L2     = 4'd2;
  localparam logic [3:0] S_L3     = 4'd3;
  localparam logic [3:0] S_R1     = 4'd4;
  localparam logic [3:0] S_R2     = 4'd5;
  localparam logic [3:0] S_R3     = 4'd6;
  localparam logic [3:0] S_HZ     = 4'd7;
  localparam logic [3:0] S_RESYNC = 4'd8;

  localparam int HOLD_W = $clog2(STEP_CYCLES + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(STEP_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  // Lamp patterns as {l, r}
  localparam logic [5:0] P_OFF = 6'b000_000;
  localparam logic [5:0] P_L1  = 6'b001_000;
  localparam logic [5:0] P_L2  = 6'b011_000;
  localparam logic [5:0] P_L3  = 6'b111_000;
  localparam logic [5:0] P_R1  = 6'b000_001;
  localparam logic [5:0] P_R2  = 6'b000_011;
  localparam logic [5:0] P_R3  = 6'b000_111;
  localparam logic [5:0] P_HZ  = 6'b111_111;

  logic [3:0]        state, state_n;
  logic [HOLD_W-1:0] hold, hold_n;
  logic [IDLE_W-1:0] idle_cnt, idle_n;
  logic [1:0]        mode_n;
  logic              valid_n, done_n, err_n;
  logic [CNT_W-1:0]  cyc_n, errc_n;

  logic [5:0] pat;
  logic [5:0] cur_p, nxt_p;
  logic [3:0] adv_state;
  logic       terminal;
  logic [1:0] term_mode;

  assign pat = {l, r};

  // Per-step expectations: pattern being held, pattern that legally follows it.
  always_comb begin
    cur_p     = P_OFF;
    nxt_p     = P_OFF;
    adv_state = S_IDLE;
    terminal  = 1'b0;
    term_mode = 2'b00;
    case (state)
      S_L1: begin cur_p = P_L1; nxt_p = P_L2; adv_state = S_L2; end
      S_L2: begin cur_p = P_L2; nxt_p = P_L3; adv_state = S_L3; end
      S_L3: begin cur_p = P_L3; nxt_p = P_OFF; terminal = 1'b1; term_mode = 2'b01; end
      S_R1: begin cur_p = P_R1; nxt_p = P_R2; adv_state = S_R2; end
      S_R2: begin cur_p = P_R2; nxt_p = P_R3; adv_state = S_R3; end
      S_R3: begin cur_p = P_R3; nxt_p = P_OFF; terminal = 1'b1; term_mode = 2'b10; end
      S_HZ: begin cur_p = P_HZ; nxt_p = P_OFF; terminal = 1'b1; term_mode = 2'b11; end
      default: ;
    endcase
  end

  always_comb begin
    logic fault;
    fault   = 1'b0;
    state_n = state;
    hold_n  = hold;
    idle_n  = idle_cnt;
    mode_n  = mode;
    valid_n = mode_valid;
    done_n  = 1'b0;
    err_n   = 1'b0;
    cyc_n   = cycle_count;
    errc_n  = err_count;

    case (state)
      S_IDLE: begin
        if (pat == P_OFF) begin
          if (idle_cnt != IDLE_MAX) idle_n = idle_cnt + IDLE_W'(1);
          if (idle_cnt >= IDLE_LAST) mode_n = 2'b00;
        end else if (pat == P_L1 || pat == P_R1 || pat == P_HZ) begin
          state_n = (pat == P_L1) ? S_L1 : (pat == P_R1) ? S_R1 : S_HZ;
          hold_n  = HOLD_W'(1);
          idle_n  = '0;
        end else begin
          fault = 1'b1;
        end
      end
      S_RESYNC: begin
        if (pat == P_OFF) begin
          state_n = S_IDLE;
          idle_n  = '0;
        end
      end
      default: begin
        if (pat == cur_p) begin
          if (hold < HOLD_MAX) hold_n = hold + HOLD_W'(1);
          else                 fault  = 1'b1;
        end else if (pat == nxt_p && hold == HOLD_MAX) begin
          if (terminal) begin
            state_n = S_IDLE;
            hold_n  = '0;
            idle_n  = '0;
            mode_n  = term_mode;
            valid_n = 1'b1;
            done_n  = 1'b1;
            cyc_n   = cycle_count + CNT_W'(1);
          end else begin
            state_n = adv_state;
            hold_n  = HOLD_W'(1);
          end
        end else begin
          fault = 1'b1;
        end
      end
    endcase

    if (fault) begin
      state_n = S_RESYNC;
      hold_n  = '0;
      idle_n  = '0;
      valid_n = 1'b0;
      err_n   = 1'b1;
      if (err_count != {CNT_W{1'b1}}) errc_n = err_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      hold        <= '0;
      idle_cnt    <= '0;
      mode        <= 2'b00;
      mode_valid  <= 1'b0;
      cycle_done  <= 1'b0;
      seq_error   <= 1'b0;
      cycle_count <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      hold        <= hold_n;
      idle_cnt    <= idle_n;
      mode        <= mode_n;
      mode_valid  <= valid_n;
      cycle_done  <= done_n;
      seq_error   <= err_n;
      cycle_count <= cyc_n;
      err_count   <= errc_n;
    end
  end

endmodule

// File: tb/tb_tail_light_decoder.sv
// Directed bench for tail_light_decoder: vector table plus reset, wrap and saturation sequences.
module tb_tail_light_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] l, r;
  logic [1:0] mode;
  logic       mode_valid, cycle_done, seq_error;
  logic [7:0] cycle_count, err_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tail_light_decoder #(.STEP_CYCLES(1), .IDLE_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .l(l), .r(r),
    .mode(mode), .mode_valid(mode_valid), .cycle_done(cycle_done),
    .seq_error(seq_error), .cycle_count(cycle_count), .err_count(err_count)
  );

  typedef struct {
    logic [2:0] l;
    logic [2:0] r;
    logic [1:0] mode;
    logic       vld;
    logic       done;
    logic       err;
    logic [7:0] cc;
    logic [7:0] ec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [2:0] vl, input logic [2:0] vr, input int m, input int v,
                     input int d, input int e, input int cc, input int ec);
    vec_t x;
    x.l = vl; x.r = vr; x.mode = 2'(m); x.vld = 1'(v); x.done = 1'(d); x.err = 1'(e);
    x.cc = 8'(cc); x.ec = 8'(ec);
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int m, input int v, input int d, input int e,
                         input int cc, input int ec);
    chk({tag, ".mode"},        32'(mode),        32'(m));
    chk({tag, ".mode_valid"},  32'(mode_valid),  32'(v));
    chk({tag, ".cycle_done"},  32'(cycle_done),  32'(d));
    chk({tag, ".seq_error"},   32'(seq_error),   32'(e));
    chk({tag, ".cycle_count"}, 32'(cycle_count), 32'(cc));
    chk({tag, ".err_count"},   32'(err_count),   32'(ec));
  endtask

  task automatic step(input logic [2:0] vl, input logic [2:0] vr);
    l = vl;
    r = vr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Left cycle
    add(3'b001,3'b000, 0,0,0,0, 0,0);
    add(3'b011,3'b000, 0,0,0,0, 0,0);
    add(3'b111,3'b000, 0,0,0,0, 0,0);
    add(3'b000,3'b000, 1,1,1,0, 1,0);
    // Three back-to-back right cycles
    for (int k = 0; k < 3; k++) begin
      add(3'b000,3'b001, (k == 0) ? 1 : 2,1,0,0, 1+k,0);
      add(3'b000,3'b011, (k == 0) ? 1 : 2,1,0,0, 1+k,0);
      add(3'b000,3'b111, (k == 0) ? 1 : 2,1,0,0, 1+k,0);
      add(3'b000,3'b000, 2,1,1,0, 2+k,0);
    end
    // Five hazard cycles
    for (int k = 0; k < 5; k++) begin
      add(3'b111,3'b111, (k == 0) ? 2 : 3,1,0,0, 4+k,0);
      add(3'b000,3'b000, 3,1,1,0, 5+k,0);
    end
    // Idle timeout on the 4th all-off sample, then saturated
    add(3'b000,3'b000, 3,1,0,0, 9,0);
    add(3'b000,3'b000, 3,1,0,0, 9,0);
    add(3'b000,3'b000, 3,1,0,0, 9,0);
    add(3'b000,3'b000, 0,1,0,0, 9,0);
    add(3'b000,3'b000, 0,1,0,0, 9,0);
    // Skipped step, resync ignores lamps until all-off, then a clean left cycle
    add(3'b001,3'b000, 0,1,0,0, 9,0);
    add(3'b111,3'b000, 0,0,0,1, 9,1);
    add(3'b011,3'b000, 0,0,0,0, 9,1);
    add(3'b000,3'b000, 0,0,0,0, 9,1);
    add(3'b001,3'b000, 0,0,0,0, 9,1);
    add(3'b011,3'b000, 0,0,0,0, 9,1);
    add(3'b111,3'b000, 0,0,0,0, 9,1);
    add(3'b000,3'b000, 1,1,1,0, 10,1);
    // Step held too long; mid-sequence pattern from idle; hazard held too long
    add(3'b001,3'b000, 1,1,0,0, 10,1);
    add(3'b001,3'b000, 1,0,0,1, 10,2);
    add(3'b000,3'b000, 1,0,0,0, 10,2);
    add(3'b011,3'b000, 1,0,0,1, 10,3);
    add(3'b000,3'b000, 1,0,0,0, 10,3);
    add(3'b111,3'b111, 1,0,0,0, 10,3);
    add(3'b111,3'b111, 1,0,0,1, 10,4);
    add(3'b000,3'b000, 1,0,0,0, 10,4);
    // Start on the timeout edge wins: mode is not cleared
    add(3'b000,3'b000, 1,0,0,0, 10,4);
    add(3'b000,3'b000, 1,0,0,0, 10,4);
    add(3'b000,3'b000, 1,0,0,0, 10,4);
    add(3'b000,3'b001, 1,0,0,0, 10,4);
    add(3'b000,3'b011, 1,0,0,0, 10,4);
    add(3'b000,3'b111, 1,0,0,0, 10,4);
    add(3'b000,3'b000, 2,1,1,0, 11,4);

    reset = 1'b1;
    l = 3'b000;
    r = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0,0,0,0, 0,0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].l, tbl[i].r);
      chk_all($sformatf("v%0d", i), int'(tbl[i].mode), int'(tbl[i].vld), int'(tbl[i].done),
              int'(tbl[i].err), int'(tbl[i].cc), int'(tbl[i].ec));
    end

    // Asynchronous reset between edges, part-way through a left cycle
    step(3'b001, 3'b000);
    step(3'b011, 3'b000);
    #3 reset = 1'b1;
    #1;
    chk_all("async_reset", 0,0,0,0, 0,0);
    #2 reset = 1'b0;
    step(3'b111, 3'b000);
    chk_all("resume_midcycle", 0,0,0,1, 0,1);
    step(3'b000, 3'b000);
    chk_all("resync_exit", 0,0,0,0, 0,1);

    // cycle_count wraps from all-ones to zero
    for (int k = 0; k < 255; k++) begin
      step(3'b111, 3'b111);
      step(3'b000, 3'b000);
    end
    chk("cc_at_max", 32'(cycle_count), 32'd255);
    step(3'b111, 3'b111);
    step(3'b000, 3'b000);
    chk_all("cc_wrap", 3,1,1,0, 0,1);

    // err_count saturates at all-ones
    for (int k = 0; k < 254; k++) begin
      step(3'b011, 3'b000);
      step(3'b000, 3'b000);
    end
    chk("ec_at_max", 32'(err_count), 32'd255);
    step(3'b011, 3'b000);
    chk_all("ec_saturate", 3,0,0,1, 0,255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
